// File: rtl/z80_seq_ret_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : z80_seq_ret_cond_pkg
//  Description : Shared constants and types for the RET cc sequencer and the
//                condition evaluator used by the conditional-flow sequencers.
//  Revision    : 1.0 - initial release
// ============================================================================
package z80_seq_ret_cond_pkg;

  // Bit positions of the flags tested by conditional instructions
  localparam int FLAG_C_NUM  = 0;
  localparam int FLAG_PV_NUM = 2;
  localparam int FLAG_Z_NUM  = 6;
  localparam int FLAG_S_NUM  = 7;

  // RET cc is 11ccc000
  localparam logic [7:0] RET_CC_MASK  = 8'hC7;
  localparam logic [7:0] RET_CC_MATCH = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EVAL  = 3'd1,
    ST_RD_LO = 3'd2,
    ST_RD_HI = 3'd3,
    ST_DONE  = 3'd4
  } ret_state_t;

  function automatic logic is_ret_cc(input logic [7:0] op);
    return (op & RET_CC_MASK) == RET_CC_MATCH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : z80_cond_eval
//  Description : Combinational condition-code evaluator: (cc, F) -> met.
//                cc[2:1] selects Z / C / P/V / S, cc[0] is the required sense.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_cond_eval
  import z80_seq_ret_cond_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [7:0] f,
  output logic       met
);

  logic flag;
  logic unused_f;

  // H, N and the undocumented bits never take part in a condition
  assign unused_f = ^{f[5], f[4], f[3], f[1]};

  // Select the tested flag, then compare it with the sense bit
  always_comb begin
    flag = 1'b0;
    case (cc[2:1])
      2'd0: flag = f[FLAG_Z_NUM];
      2'd1: flag = f[FLAG_C_NUM];
      2'd2: flag = f[FLAG_PV_NUM];
      2'd3: flag = f[FLAG_S_NUM];
    endcase
    met = (flag == cc[0]);
  end

endmodule
`default_nettype wire

// File: rtl/z80_seq_ret_cond.sv
`default_nettype none
// ============================================================================
//  Module      : z80_seq_ret_cond
//  Description : Execution sequencer for RET cc. Evaluates the condition in
//                the extra M1 T-state(s) and, when met, pops IP from the stack
//                through the shared memory-read bus engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_seq_ret_cond
  import z80_seq_ret_cond_pkg::*;
#(
  parameter int EXTRA_M1_T = 1,
  parameter int TCNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        opcode,
  input  logic [7:0]        reg_f_in,
  input  logic [15:0]       reg_sp_in,
  input  logic [15:0]       reg_ip_in,
  output logic              rd_req,
  output logic [15:0]       rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              ip_we,
  output logic              sp_we,
  output logic [15:0]       reg_ip_out,
  output logic [15:0]       reg_sp_out,
  output logic              cond_met,
  output logic [TCNT_W-1:0] tcycles,
  output logic              illegal
);

  localparam int          EW        = 8;
  localparam logic [EW-1:0] EVAL_LAST = EW'(EXTRA_M1_T - 1);

  ret_state_t        state, state_nx;
  logic [2:0]        cc_q;
  logic [7:0]        f_q, lo_q, hi_q;
  logic [15:0]       sp_q, ip_q;
  logic [TCNT_W-1:0] tcount, tcount_inc;
  logic [EW-1:0]     eval_cnt;
  logic              req_q, illegal_q, met, start_ok;

  assign start_ok   = start && (state == ST_IDLE) && is_ret_cc(opcode);
  assign tcount_inc = (&tcount) ? tcount : tcount + TCNT_W'(1);

  z80_cond_eval u_cond_eval (
    .cc  (cc_q),
    .f   (f_q),
    .met (met)
  );

  assign busy     = (state != ST_IDLE);
  assign cond_met = busy && met;
  assign rd_req   = req_q;
  assign illegal  = illegal_q;
  assign tcycles  = tcount;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state and writeback decode
  always_comb begin
    state_nx   = state;
    rd_addr    = 16'h0000;
    done       = 1'b0;
    ip_we      = 1'b0;
    sp_we      = 1'b0;
    reg_ip_out = 16'h0000;
    reg_sp_out = 16'h0000;
    case (state)
      ST_IDLE: if (start_ok) state_nx = ST_EVAL;
      ST_EVAL: if (eval_cnt == EVAL_LAST) state_nx = met ? ST_RD_LO : ST_DONE;
      ST_RD_LO: begin
        rd_addr = sp_q;
        if (req_q && rd_ack) state_nx = ST_RD_HI;
      end
      ST_RD_HI: begin
        rd_addr = sp_q + 16'd1;
        if (req_q && rd_ack) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        ip_we    = 1'b1;
        state_nx = ST_IDLE;
        if (met) begin
          reg_ip_out = {hi_q, lo_q};
          reg_sp_out = sp_q + 16'd2;
          sp_we      = 1'b1;
        end else begin
          reg_ip_out = ip_q + 16'd1;
          reg_sp_out = sp_q;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand latches, T-state count and read-request handshake.
  // Each read spends one cycle with rd_req low before requesting, so the
  // request always drops between the low and high byte reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc_q      <= 3'd0;
      f_q       <= 8'h00;
      sp_q      <= 16'h0000;
      ip_q      <= 16'h0000;
      lo_q      <= 8'h00;
      hi_q      <= 8'h00;
      tcount    <= '0;
      eval_cnt  <= '0;
      req_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= start && (state == ST_IDLE) && !is_ret_cc(opcode);
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            cc_q     <= opcode[5:3];
            f_q      <= reg_f_in;
            sp_q     <= reg_sp_in;
            ip_q     <= reg_ip_in;
            tcount   <= TCNT_W'(4);
            eval_cnt <= '0;
          end
        end
        ST_EVAL: begin
          eval_cnt <= eval_cnt + 8'd1;
          tcount   <= tcount_inc;
        end
        ST_RD_LO, ST_RD_HI: begin
          tcount <= tcount_inc;
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (rd_ack) begin
            req_q <= 1'b0;
            if (state == ST_RD_LO) lo_q <= rd_data;
            else                   hi_q <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z80_seq_ret_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_seq_ret_cond
//  Description : Directed self-checking bench for the RET cc sequencer with a
//                simple bus-engine model that acks after a set number of
//                rd_req cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_z80_seq_ret_cond;

  logic        clk = 1'b0;
  logic        reset_n, start, rd_ack;
  logic [7:0]  opcode, reg_f_in, rd_data;
  logic [15:0] reg_sp_in, reg_ip_in;
  logic        rd_req, busy, done, ip_we, sp_we, cond_met, illegal;
  logic [15:0] rd_addr, reg_ip_out, reg_sp_out;
  logic [4:0]  tcycles;

  logic [7:0]  mem [0:65535];
  logic [15:0] addr_log [0:255];
  int          ack_lat = 2;
  int          age, n_reads = 0;
  int          checks = 0, failures = 0;

  // Results captured by run_insn
  logic        r_done, r_spwe, r_ipwe, r_met, r_ill_seen, r_busy_after;
  logic [15:0] r_ip, r_sp, r_a0, r_a1;
  logic [4:0]  r_t;
  int          r_reads;

  always #5 clk = ~clk;

  z80_seq_ret_cond #(.EXTRA_M1_T(1), .TCNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .reg_f_in(reg_f_in), .reg_sp_in(reg_sp_in), .reg_ip_in(reg_ip_in),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .busy(busy), .done(done), .ip_we(ip_we), .sp_we(sp_we),
    .reg_ip_out(reg_ip_out), .reg_sp_out(reg_sp_out), .cond_met(cond_met),
    .tcycles(tcycles), .illegal(illegal)
  );

  // Bus engine model: ack on the ack_lat-th consecutive cycle of rd_req
  initial begin
    rd_ack = 1'b0; rd_data = 8'h00; age = 0;
    forever begin
      @(posedge clk); #1;
      if (rd_req) begin
        age++;
        if (age == ack_lat) begin
          rd_ack = 1'b1;
          rd_data = mem[rd_addr];
          addr_log[n_reads % 256] = rd_addr;
          n_reads++;
        end else begin
          rd_ack = 1'b0;
          rd_data = 8'h00;
        end
      end else begin
        age = 0;
        rd_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic run_insn(input logic [7:0] op, input logic [7:0] f,
                          input logic [15:0] sp, input logic [15:0] ip,
                          input int lat, input int inj_at, input logic [7:0] inj_op);
    int base;
    base = n_reads;
    ack_lat = lat;
    r_done = 0; r_ill_seen = 0; r_ip = 0; r_sp = 0; r_spwe = 0; r_ipwe = 0;
    r_met = 0; r_t = 0;
    @(posedge clk); #1;
    start = 1; opcode = op; reg_f_in = f; reg_sp_in = sp; reg_ip_in = ip;
    @(posedge clk); #1;
    start = 0; opcode = 8'h00; reg_f_in = 8'hAA; reg_sp_in = 16'h0; reg_ip_in = 16'h0;
    for (int i = 0; i < 200; i++) begin
      if (illegal) r_ill_seen = 1;
      if (done) begin
        r_done = 1; r_ip = reg_ip_out; r_sp = reg_sp_out; r_spwe = sp_we;
        r_ipwe = ip_we; r_met = cond_met; r_t = tcycles;
        break;
      end
      if (i == inj_at) begin
        start = 1; opcode = inj_op; reg_f_in = ~f;
        reg_sp_in = 16'h4000; reg_ip_in = 16'h5555;
      end else begin
        start = 0;
      end
      @(posedge clk); #1;
    end
    start = 0;
    @(posedge clk); #1;
    if (illegal) r_ill_seen = 1;
    r_busy_after = busy;
    r_reads = n_reads - base;
    r_a0 = addr_log[base % 256];
    r_a1 = addr_log[(base + 1) % 256];
    checks++;
    if (r_done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout op=%h: actual done=%b required=1", op, r_done);
    end
    checks++;
    if (r_busy_after !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_done op=%h: actual=%b required=0", op, r_busy_after);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; start = 0; opcode = 0; reg_f_in = 0; reg_sp_in = 0; reg_ip_in = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: actual busy=%b rd_req=%b done=%b required 0 0 0", busy, rd_req, done);
    end
    checks++;
    if (rd_addr !== 16'h0000 || tcycles !== 5'd0) begin
      failures++;
      $display("FAIL reset_data: actual rd_addr=%h tcycles=%0d required 0000 0", rd_addr, tcycles);
    end
    checks++;
    if ({ip_we, sp_we, illegal, cond_met} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: actual {ip_we,sp_we,illegal,cond_met}=%b required 0000",
               {ip_we, sp_we, illegal, cond_met});
    end
    reset_n = 1;
  endtask

  task automatic test_not_met();
    run_insn(8'hC8, 8'h00, 16'h8000, 16'h1000, 2, -1, 8'h00);
    checks++;
    if (r_ip !== 16'h1001 || r_sp !== 16'h8000) begin
      failures++;
      $display("FAIL not_met_regs: actual ip=%h sp=%h required 1001 8000", r_ip, r_sp);
    end
    checks++;
    if (r_ipwe !== 1'b1 || r_spwe !== 1'b0 || r_met !== 1'b0) begin
      failures++;
      $display("FAIL not_met_we: actual ip_we=%b sp_we=%b met=%b required 1 0 0", r_ipwe, r_spwe, r_met);
    end
    checks++;
    if (r_t !== 5'd5 || r_reads !== 0) begin
      failures++;
      $display("FAIL not_met_timing: actual t=%0d reads=%0d required 5 0", r_t, r_reads);
    end
  endtask

  task automatic test_met();
    mem[16'h8000] = 8'h34; mem[16'h8001] = 8'h12;
    run_insn(8'hC8, 8'h40, 16'h8000, 16'h1000, 2, -1, 8'h00);
    checks++;
    if (r_ip !== 16'h1234 || r_sp !== 16'h8002) begin
      failures++;
      $display("FAIL met_regs: actual ip=%h sp=%h required 1234 8002", r_ip, r_sp);
    end
    checks++;
    if (r_spwe !== 1'b1 || r_ipwe !== 1'b1 || r_met !== 1'b1) begin
      failures++;
      $display("FAIL met_we: actual sp_we=%b ip_we=%b met=%b required 1 1 1", r_spwe, r_ipwe, r_met);
    end
    checks++;
    if (r_reads !== 2 || r_a0 !== 16'h8000 || r_a1 !== 16'h8001) begin
      failures++;
      $display("FAIL met_addrs: actual reads=%0d a0=%h a1=%h required 2 8000 8001", r_reads, r_a0, r_a1);
    end
    checks++;
    if (r_t !== 5'd11) begin
      failures++;
      $display("FAIL met_tcycles: actual=%0d required=11", r_t);
    end
  endtask

  task automatic test_wait_wrap();
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    run_insn(8'hF0, 8'h00, 16'hFFFF, 16'h0100, 4, -1, 8'h00);
    checks++;
    if (r_ip !== 16'hABCD || r_sp !== 16'h0001 || r_spwe !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ffff_regs: actual ip=%h sp=%h sp_we=%b required ABCD 0001 1", r_ip, r_sp, r_spwe);
    end
    checks++;
    if (r_a0 !== 16'hFFFF || r_a1 !== 16'h0000 || r_t !== 5'd15) begin
      failures++;
      $display("FAIL wrap_ffff_bus: actual a0=%h a1=%h t=%0d required FFFF 0000 15", r_a0, r_a1, r_t);
    end
    // RET C with C set, SP=FFFE, ack in the first rd_req cycle
    mem[16'hFFFE] = 8'h77;
    run_insn(8'hD8, 8'h01, 16'hFFFE, 16'h0100, 1, -1, 8'h00);
    checks++;
    if (r_ip !== 16'hCD77 || r_sp !== 16'h0000 || r_t !== 5'd9) begin
      failures++;
      $display("FAIL wrap_fffe: actual ip=%h sp=%h t=%0d required CD77 0000 9", r_ip, r_sp, r_t);
    end
  endtask

  task automatic test_cond_table();
    logic [7:0] vf [12] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h04, 8'h04,
                            8'h04, 8'h80, 8'h80, 8'h40, 8'h40, 8'h80};
    logic [2:0] vc [12] = '{3'd3, 3'd2, 3'd1, 3'd7, 3'd5, 3'd4,
                            3'd0, 3'd7, 3'd6, 3'd1, 3'd0, 3'd1};
    logic       ve [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                            1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] f;
    logic [2:0] cc;
    logic       exp;
    mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22;
    for (int k = 0; k < 28; k++) begin
      if (k < 16) begin
        cc = 3'(k % 8);
        f = (k < 8) ? 8'hFF : 8'h00;
        exp = (k < 8) ? cc[0] : ~cc[0];
      end else begin
        cc = vc[k-16]; f = vf[k-16]; exp = ve[k-16];
      end
      run_insn({2'b11, cc, 3'b000}, f, 16'h2000, 16'h0500, 2, -1, 8'h00);
      checks++;
      if (r_met !== exp || r_spwe !== exp || r_t !== (exp ? 5'd11 : 5'd5)) begin
        failures++;
        $display("FAIL cond cc=%0d f=%h: actual met=%b sp_we=%b t=%0d required met=%b",
                 cc, f, r_met, r_spwe, r_t, exp);
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] ops [4] = '{8'hC9, 8'hC4, 8'h00, 8'hC1};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start = 1; opcode = ops[k];
      @(posedge clk); #1;
      start = 0;
      checks++;
      if (illegal !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal_pulse op=%h: actual illegal=%b busy=%b required 1 0", ops[k], illegal, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (illegal !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal_end op=%h: actual illegal=%b busy=%b required 0 0", ops[k], illegal, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic found, bad;
    found = 0; bad = 0;
    mem[16'h8000] = 8'h34; mem[16'h8001] = 8'h12;
    ack_lat = 4;
    @(posedge clk); #1;
    start = 1; opcode = 8'hC8; reg_f_in = 8'h40; reg_sp_in = 16'h8000; reg_ip_in = 16'h1000;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 50; i++) begin
      if (rd_req && rd_addr == 16'h8001) begin found = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_reach: actual no RD_HI request required rd_req at 8001");
    end
    reset_n = 0;
    #1;
    checks++;
    if (rd_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_drop: actual rd_req=%b busy=%b done=%b addr=%h required 0 0 0 0000",
               rd_req, busy, done, rd_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ip_we || sp_we || done) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_wb: actual writeback seen=%b required 0", bad);
    end
    reset_n = 1;
    run_insn(8'hC0, 8'h40, 16'h3000, 16'h2222, 2, -1, 8'h00);
    checks++;
    if (r_ip !== 16'h2223 || r_sp !== 16'h3000 || r_spwe !== 1'b0 || r_t !== 5'd5) begin
      failures++;
      $display("FAIL reset_mid_after: actual ip=%h sp=%h sp_we=%b t=%0d required 2223 3000 0 5",
               r_ip, r_sp, r_spwe, r_t);
    end
  endtask

  task automatic test_back_to_back();
    mem[16'h8000] = 8'h34; mem[16'h8001] = 8'h12;
    // Legal start during EVAL with different operands must not relatch
    run_insn(8'hC8, 8'h40, 16'h8000, 16'h1000, 2, 0, 8'hC0);
    checks++;
    if (r_ip !== 16'h1234 || r_sp !== 16'h8002 || r_t !== 5'd11) begin
      failures++;
      $display("FAIL busy_relatch: actual ip=%h sp=%h t=%0d required 1234 8002 11", r_ip, r_sp, r_t);
    end
    // Illegal opcode while reading must not pulse illegal
    run_insn(8'hC8, 8'h40, 16'h8000, 16'h1000, 2, 3, 8'hC9);
    checks++;
    if (r_ill_seen !== 1'b0 || r_ip !== 16'h1234) begin
      failures++;
      $display("FAIL busy_illegal: actual illegal_seen=%b ip=%h required 0 1234", r_ill_seen, r_ip);
    end
  endtask

  initial begin
    test_reset();
    test_not_met();
    test_met();
    test_wait_wrap();
    test_cond_table();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z80_seq_ret_cond.md
Name: z80_seq_ret_cond

Overview:
- Execution sequencer for RET cc (opcode 11ccc000) in the vz80core datapath.
- Pops the return address pushed by a prior CALL: reads low byte at SP, then high byte at SP+1. Writes IP, and writes SP+2.
- Sits between the decoder, which issues `start` during M1 T4, and the shared memory-read bus engine, which owns T-state timing and wait states.
- On the formal interface, its results must match the RET cc insn spec: 5T when the condition is not met; 5+3+3T when it is met.

Parameters:
- EXTRA_M1_T, default 1: extra T-states appended to M1 for condition evaluation (T5).
- TCNT_W, default 5: width of the T-state counter.

Ports:
- clk  in  1  T-state clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; decoder has an opcode for this block.
- opcode  in  8  instruction byte, sampled at start.
- reg_f_in  in  8  flags, sampled at start.
- reg_sp_in  in  16  SP, sampled at start.
- reg_ip_in  in  16  address of the opcode, sampled at start.
- rd_req  out  1  memory read request; held until acknowledged.
- rd_addr  out  16  read address; stable while rd_req=1.
- rd_ack  in  1  bus engine completed the read; rd_data valid this cycle.
- rd_data  in  8  read byte.
- busy  out  1  high from the cycle after an accepted start until the cycle after done.
- done  out  1  one-cycle completion pulse.
- ip_we  out  1  IP writeback enable; pulses with done.
- sp_we  out  1  SP writeback enable; pulses with done only if the condition is met.
- reg_ip_out  out  16  new IP; valid when done=1.
- reg_sp_out  out  16  new SP; valid when done=1.
- cond_met  out  1  latched condition result; valid from T5 through done.
- tcycles  out  TCNT_W  T-states consumed, counting the 4 of M1; valid at done; saturates at all-ones.
- illegal  out  1  one-cycle pulse: start with an opcode not matching 11???000.

Behaviour:
- Reset: the asynchronous assert of reset_n=0 forces state IDLE. All outputs go to 0, rd_addr=0, internal latches cleared. There is no writeback on reset mid-operation, and any outstanding rd_req is dropped immediately.
- States: IDLE, EVAL, RD_LO, RD_HI, DONE.
- IDLE:
  - start=1 with opcode[7:6]=11 and opcode[2:0]=000 -> latch the inputs; go to EVAL; tcount=4.
  - start=1 with any other opcode -> illegal=1 for one cycle; stay in IDLE.
  - start=0 -> no action.
- EVAL:
  - Lasts EXTRA_M1_T cycles, incrementing tcount each cycle.
  - cc=opcode[5:3]. Flag select: cc 0/1 -> Z; 2/3 -> C; 4/5 -> P/V; 6/7 -> S.
  - cond_met = (F[flag] == cc[0]), using the latched F.
  - At the end of EVAL: met -> RD_LO; not met -> DONE.
- RD_LO:
  - rd_req=1, rd_addr=sp.
  - On rd_ack: latch lo=rd_data, deassert rd_req that same edge, go to RD_HI.
  - tcount increments every cycle spent here, including wait states.
- RD_HI:
  - rd_req=1, rd_addr=sp+1 (16-bit wrap).
  - On rd_ack: latch hi, go to DONE. tcount increments as in RD_LO.
- DONE: lasts one cycle. done=1, ip_we=1, then return to IDLE.
  - Met: reg_ip_out={hi,lo}, reg_sp_out=sp+2 (mod 2^16), sp_we=1.
  - Not met: reg_ip_out=ip+1 (mod 2^16), reg_sp_out=sp, sp_we=0.
- Handshake:
  - rd_ack is ignored unless rd_req=1.
  - rd_ack may arrive in the first cycle of rd_req.
  - rd_req goes low for at least one cycle between the two reads, because the state changes.
- start while busy=1 is ignored: no illegal pulse, no relatch.
- Wrap-around: SP=FFFF reads FFFF, then 0000, and gives SP_out=0001. SP=FFFE gives SP_out=0000.
- Nominal tcycles with zero wait states: 5 when not met, 11 when met.

Decomposition:
- Shared package/header (z80.vh):
  - Existing FLAG_*_NUM constants.
  - New RET_CC opcode mask/match constants.
  - A state enum typedef.
- Sub-module z80_cond_eval: combinational, (cc[2:0], F[7:0]) -> met. Shared with the JP cc, CALL cc and JR cc sequencers.

Test Plan:
- Not met: F=00, opcode C8 (RET Z), IP=1000, SP=8000 -> done after EVAL; IP_out=1001; sp_we=0; no rd_req; tcycles=5.
- Met, no waits: F=40, opcode C8, SP=8000, mem[8000]=34, mem[8001]=12 -> rd_addr 8000 then 8001; IP_out=1234; SP_out=8002; sp_we=1; tcycles=11.
- Wait states and wrap: opcode F0 (RET P), F=00, SP=FFFF, rd_ack delayed 2 extra cycles per read, mem[FFFF]=CD, mem[0000]=AB -> IP_out=ABCD; SP_out=0001; tcycles=15.
- All eight cc values against F=FF and F=00 -> cond_met matches the flag table. Illegal opcode C9 -> illegal pulse, busy stays 0.
- Reset: reset_n=0 asserted while rd_req=1 in RD_HI -> rd_req, busy and done go 0 immediately; no ip_we or sp_we; a new start after release completes normally.
- start pulsed while busy -> ignored; the results of the first instruction are unchanged.
